axi_traffic_gen: RTL and testbench

// Parametrised AXI4 master traffic generator for bring-up of the CVA6 APU memory path.
// On start, writes NUM_BURSTS INCR bursts of BURST_LEN beats with a counting data pattern

---
 rtl/axi_traffic_gen_if.sv | 88 ++++++++
 rtl/axi_traffic_gen.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi_traffic_gen.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_traffic_gen_if.sv
// AXI4 bus bundle shared by the traffic generator and its slave.
// Master/Slave modports give the handshake direction for each side.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 10
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [5:0]                  aw_atop;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_traffic_gen.sv
// AXI4 write-then-readback traffic generator for memory path bring-up.
// Writes a counting pattern in INCR bursts, reads it back and counts errors.
module axi_traffic_gen #(
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 10,
    parameter logic [AXI_ADDR_WIDTH-1:0] START_ADDR = 'h9000_0000,
    parameter int unsigned NUM_BURSTS     = 4,
    parameter int unsigned BURST_LEN      = 8,
    parameter logic [AXI_DATA_WIDTH-1:0] DATA_SEED = 'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] mism_cnt_o,
    output logic [15:0] resp_err_cnt_o,
    AXI_BUS.Master      axi_master_port
);
    localparam int unsigned BYTES  = AXI_DATA_WIDTH / 8;
    localparam int unsigned BBYTES = BURST_LEN * BYTES;
    localparam int unsigned GW     = $clog2(NUM_BURSTS * BURST_LEN) + 1;
    localparam logic [2:0]  SIZE   = 3'($clog2(BYTES));
    localparam logic [7:0]  LEN    = 8'(BURST_LEN - 1);
    localparam logic [15:0] LAST_B = 16'(NUM_BURSTS - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = AXI_ADDR_WIDTH'(BYTES - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BSTEP      = AXI_ADDR_WIDTH'(BBYTES);

    function automatic bit crosses_4k();
        bit hit;
        longint unsigned off;
        hit = 1'b0;
        for (longint unsigned b = 0; b < NUM_BURSTS; b++) begin
            off = (64'(START_ADDR[11:0]) + b * BBYTES) % 4096;
            if (off + BBYTES > 4096) hit = 1'b1;
        end
        return hit;
    endfunction

    if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_len_chk
        $error("axi_traffic_gen: BURST_LEN must be 1..256");
    end
    if (NUM_BURSTS < 1 || NUM_BURSTS > 65535) begin : g_num_chk
        $error("axi_traffic_gen: NUM_BURSTS must be 1..65535");
    end
    if ((START_ADDR & ALIGN_MASK) != '0) begin : g_align_chk
        $error("axi_traffic_gen: START_ADDR not aligned to bus width");
    end
    if (crosses_4k()) begin : g_4k_chk
        $error("axi_traffic_gen: a burst crosses a 4 KiB boundary");
    end

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
    } state_e;

    state_e          state_q;
    logic [15:0]     burst_q;
    logic [7:0]      beat_q;
    logic [GW-1:0]   gbeat_q;
    logic            aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
    logic            busy_q, done_q, pass_q;
    logic [15:0]     mism_q, err_q, mism_nxt, err_nxt;
    logic            last_beat, last_burst;
    logic [AXI_DATA_WIDTH-1:0] pattern;
    logic [AXI_ADDR_WIDTH-1:0] burst_addr;
    logic            unused_resp;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign last_beat  = (beat_q == LEN);
    assign last_burst = (burst_q == LAST_B);
    assign pattern    = DATA_SEED + AXI_DATA_WIDTH'(gbeat_q);
    assign burst_addr = START_ADDR + AXI_ADDR_WIDTH'(burst_q) * BSTEP;

    assign unused_resp = ^{axi_master_port.b_id, axi_master_port.b_user,
                           axi_master_port.r_id, axi_master_port.r_user};

    assign axi_master_port.aw_id     = '0;
    assign axi_master_port.aw_addr   = burst_addr;
    assign axi_master_port.aw_len    = LEN;
    assign axi_master_port.aw_size   = SIZE;
    assign axi_master_port.aw_burst  = 2'b01;
    assign axi_master_port.aw_lock   = 1'b0;
    assign axi_master_port.aw_cache  = '0;
    assign axi_master_port.aw_prot   = '0;
    assign axi_master_port.aw_qos    = '0;
    assign axi_master_port.aw_region = '0;
    assign axi_master_port.aw_atop   = '0;
    assign axi_master_port.aw_user   = '0;
    assign axi_master_port.aw_valid  = aw_valid_q;

    assign axi_master_port.w_data    = pattern;
    assign axi_master_port.w_strb    = '1;
    assign axi_master_port.w_last    = last_beat;
    assign axi_master_port.w_user    = '0;
    assign axi_master_port.w_valid   = w_valid_q;

    assign axi_master_port.b_ready   = b_ready_q;

    assign axi_master_port.ar_id     = '0;
    assign axi_master_port.ar_addr   = burst_addr;
    assign axi_master_port.ar_len    = LEN;
    assign axi_master_port.ar_size   = SIZE;
    assign axi_master_port.ar_burst  = 2'b01;
    assign axi_master_port.ar_lock   = 1'b0;
    assign axi_master_port.ar_cache  = '0;
    assign axi_master_port.ar_prot   = '0;
    assign axi_master_port.ar_qos    = '0;
    assign axi_master_port.ar_region = '0;
    assign axi_master_port.ar_user   = '0;
    assign axi_master_port.ar_valid  = ar_valid_q;

    assign axi_master_port.r_ready   = r_ready_q;

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign mism_cnt_o     = mism_q;
    assign resp_err_cnt_o = err_q;

    // Error counters as they stand after this cycle's B/R beat is judged.
    always_comb begin
        mism_nxt = mism_q;
        err_nxt  = err_q;
        if (state_q == WR_RESP && axi_master_port.b_valid &&
            axi_master_port.b_resp != 2'b00) begin
            err_nxt = sat_inc(err_q);
        end
        if (state_q == RD_DATA && axi_master_port.r_valid) begin
            if (axi_master_port.r_resp != 2'b00) err_nxt = sat_inc(err_q);
            if (axi_master_port.r_data != pattern ||
                axi_master_port.r_last != last_beat) begin
                mism_nxt = sat_inc(mism_q);
            end
        end
    end

    // Sequencer: one outstanding transaction, all handshake outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            burst_q    <= '0;
            beat_q     <= '0;
            gbeat_q    <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mism_q     <= '0;
            err_q      <= '0;
        end else begin
            mism_q <= mism_nxt;
            err_q  <= err_nxt;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q    <= WR_ADDR;
                        burst_q    <= '0;
                        beat_q     <= '0;
                        gbeat_q    <= '0;
                        aw_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        mism_q     <= '0;
                        err_q      <= '0;
                    end
                end
                WR_ADDR: begin
                    if (axi_master_port.aw_ready) begin
                        aw_valid_q <= 1'b0;
                        w_valid_q  <= 1'b1;
                        state_q    <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (axi_master_port.w_ready) begin
                        gbeat_q <= gbeat_q + 1'b1;
                        if (last_beat) begin
                            beat_q    <= '0;
                            w_valid_q <= 1'b0;
                            b_ready_q <= 1'b1;
                            state_q   <= WR_RESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_master_port.b_valid) begin
                        b_ready_q <= 1'b0;
                        if (last_burst) begin
                            burst_q    <= '0;
                            gbeat_q    <= '0;
                            ar_valid_q <= 1'b1;
                            state_q    <= RD_ADDR;
                        end else begin
                            burst_q    <= burst_q + 16'd1;
                            aw_valid_q <= 1'b1;
                            state_q    <= WR_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (axi_master_port.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi_master_port.r_valid) begin
                        gbeat_q <= gbeat_q + 1'b1;
                        if (last_beat) begin
                            beat_q    <= '0;
                            r_ready_q <= 1'b0;
                            if (last_burst) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= (mism_nxt == '0) && (err_nxt == '0);
                                state_q <= DONE;
                            end else begin
                                burst_q    <= burst_q + 16'd1;
                                ar_valid_q <= 1'b1;
                                state_q    <= RD_ADDR;
                            end
                        end else begin
                            beat_q <= beat_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_traffic_gen.sv
// Bench for axi_traffic_gen: memory slave with stalls and error injection.
// Expected beats are queued at stimulus time and popped by the slave monitor.
module tb_axi_traffic_gen;
    typedef logic [63:0] u64;
    localparam int NB = 4;
    localparam int BL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, start_i, start2;
    logic busy, done, pass, busy2, done2, pass2;
    logic [15:0] mism, errc, mism2, errc2;

    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
              .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(10)) axi ();
    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
              .AXI_ID_WIDTH(10), .AXI_USER_WIDTH(10)) axi2 ();

    axi_traffic_gen u_dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .busy_o(busy), .done_o(done), .pass_o(pass),
        .mism_cnt_o(mism), .resp_err_cnt_o(errc),
        .axi_master_port(axi)
    );

    axi_traffic_gen #(
        .START_ADDR(64'h1000), .NUM_BURSTS(1), .BURST_LEN(1), .DATA_SEED(64'h5)
    ) u_small (
        .clk_i(clk), .rst_i(rst_i), .start_i(start2),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2),
        .mism_cnt_o(mism2), .resp_err_cnt_o(errc2),
        .axi_master_port(axi2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    u64   exp_aw_q[$], exp_ar_q[$], exp_wd_q[$], exp2_q[$];
    logic exp_wl_q[$];

    bit stall_en;
    int bad_r, slverr_b, decerr_r;

    task automatic check(input string nm, input u64 got, input u64 exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic extra(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got a handshake, expected none", nm);
    endtask

    // Main slave: memory, random ready stalls, error injection, scoreboard pops.
    u64   mem [u64];
    int   aw_st, w_st, ar_st, wbeat, b_cnt, rbeat, r_glob;
    u64   waddr, raddr, d, aw_wa, w_wd, ar_wa;
    bit   b_pend, b_hs, r_pend, r_act, r_hs, aw_wt, w_wt, ar_wt;
    logic w_wl;

    always @(negedge clk) begin
        if (rst_i) begin
            axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
            axi.b_valid = 1'b0; axi.b_resp = 2'b00; axi.b_id = '0; axi.b_user = '0;
            axi.r_valid = 1'b0; axi.r_resp = 2'b00; axi.r_id = '0; axi.r_user = '0;
            axi.r_data = '0; axi.r_last = 1'b0;
            aw_st = 0; w_st = 0; ar_st = 0; wbeat = 0; rbeat = 0;
            b_pend = 0; b_hs = 0; r_pend = 0; r_act = 0; r_hs = 0;
            aw_wt = 0; w_wt = 0; ar_wt = 0;
        end else begin
            if (start_i) begin
                b_cnt = 0;
                r_glob = 0;
            end
            if (aw_wt) begin
                check("aw_hold_valid", u64'(axi.aw_valid), 1);
                check("aw_hold_addr", axi.aw_addr, aw_wa);
            end
            if (w_wt) begin
                check("w_hold_valid", u64'(axi.w_valid), 1);
                check("w_hold_data", axi.w_data, w_wd);
                check("w_hold_last", u64'(axi.w_last), u64'(w_wl));
            end
            if (ar_wt) begin
                check("ar_hold_valid", u64'(axi.ar_valid), 1);
                check("ar_hold_addr", axi.ar_addr, ar_wa);
            end
            if (b_hs) axi.b_valid = 1'b0;
            if (b_pend) begin
                axi.b_valid = 1'b1;
                axi.b_resp = (b_cnt == slverr_b) ? 2'b10 : 2'b00;
                b_cnt++;
                b_pend = 0;
            end
            b_hs = axi.b_valid && axi.b_ready;
            if (r_hs) begin
                rbeat++;
                if (rbeat == BL) begin
                    r_act = 0;
                    axi.r_valid = 1'b0;
                end
            end
            if (r_pend) begin
                r_act = 1;
                rbeat = 0;
                r_pend = 0;
            end
            if (r_act && (r_hs || !axi.r_valid)) begin
                d = mem.exists(raddr + u64'(rbeat * 8)) ? mem[raddr + u64'(rbeat * 8)] : '0;
                if (r_glob == bad_r) d = d ^ 64'h1;
                axi.r_valid = 1'b1;
                axi.r_data = d;
                axi.r_resp = (r_glob == decerr_r) ? 2'b11 : 2'b00;
                axi.r_last = (rbeat == BL - 1);
                r_glob++;
            end
            r_hs = axi.r_valid && axi.r_ready;
            if (axi.aw_valid) begin
                if (aw_st > 0) begin axi.aw_ready = 1'b0; aw_st--; end
                else axi.aw_ready = 1'b1;
            end else axi.aw_ready = 1'b0;
            if (axi.aw_valid && axi.aw_ready) begin
                if (exp_aw_q.size() == 0) extra("aw_extra");
                else check("aw_addr", axi.aw_addr, exp_aw_q.pop_front());
                check("aw_len", u64'(axi.aw_len), 7);
                check("aw_size", u64'(axi.aw_size), 3);
                check("aw_burst", u64'(axi.aw_burst), 1);
                waddr = axi.aw_addr;
                wbeat = 0;
                aw_st = stall_en ? $urandom_range(0, 5) : 0;
            end
            aw_wt = axi.aw_valid && !axi.aw_ready;
            aw_wa = axi.aw_addr;
            if (axi.w_valid) begin
                if (w_st > 0) begin axi.w_ready = 1'b0; w_st--; end
                else axi.w_ready = 1'b1;
            end else axi.w_ready = 1'b0;
            if (axi.w_valid && axi.w_ready) begin
                if (exp_wd_q.size() == 0) extra("w_extra");
                else begin
                    check("w_data", axi.w_data, exp_wd_q.pop_front());
                    check("w_last", u64'(axi.w_last), u64'(exp_wl_q.pop_front()));
                end
                mem[waddr + u64'(wbeat * 8)] = axi.w_data;
                wbeat++;
                if (axi.w_last) b_pend = 1;
                w_st = stall_en ? $urandom_range(0, 5) : 0;
            end
            w_wt = axi.w_valid && !axi.w_ready;
            w_wd = axi.w_data;
            w_wl = axi.w_last;
            if (axi.ar_valid) begin
                if (ar_st > 0) begin axi.ar_ready = 1'b0; ar_st--; end
                else axi.ar_ready = 1'b1;
            end else axi.ar_ready = 1'b0;
            if (axi.ar_valid && axi.ar_ready) begin
                if (exp_ar_q.size() == 0) extra("ar_extra");
                else check("ar_addr", axi.ar_addr, exp_ar_q.pop_front());
                raddr = axi.ar_addr;
                r_pend = 1;
                ar_st = stall_en ? $urandom_range(0, 5) : 0;
            end
            ar_wt = axi.ar_valid && !axi.ar_ready;
            ar_wa = axi.ar_addr;
        end
    end

    // Single-beat slave for the BURST_LEN=1 instance.
    int n_aw2, n_w2, n_ar2, n_r2;
    u64 wd2;
    bit b2_pend, b2_hs, r2_pend, r2_hs;

    always @(negedge clk) begin
        if (rst_i) begin
            axi2.aw_ready = 1'b0; axi2.w_ready = 1'b0; axi2.ar_ready = 1'b0;
            axi2.b_valid = 1'b0; axi2.b_resp = 2'b00; axi2.b_id = '0; axi2.b_user = '0;
            axi2.r_valid = 1'b0; axi2.r_resp = 2'b00; axi2.r_id = '0; axi2.r_user = '0;
            axi2.r_data = '0; axi2.r_last = 1'b0;
            n_aw2 = 0; n_w2 = 0; n_ar2 = 0; n_r2 = 0;
            b2_pend = 0; b2_hs = 0; r2_pend = 0; r2_hs = 0;
        end else begin
            axi2.aw_ready = 1'b1;
            axi2.w_ready = 1'b1;
            axi2.ar_ready = 1'b1;
            if (b2_hs) axi2.b_valid = 1'b0;
            if (b2_pend) begin axi2.b_valid = 1'b1; b2_pend = 0; end
            b2_hs = axi2.b_valid && axi2.b_ready;
            if (r2_hs) axi2.r_valid = 1'b0;
            if (r2_pend) begin
                axi2.r_valid = 1'b1;
                axi2.r_data = wd2;
                axi2.r_last = 1'b1;
                r2_pend = 0;
            end
            r2_hs = axi2.r_valid && axi2.r_ready;
            if (r2_hs) n_r2++;
            if (axi2.aw_valid) begin
                n_aw2++;
                if (exp2_q.size() == 0) extra("t6_aw_extra");
                else check("t6_aw_addr", axi2.aw_addr, exp2_q.pop_front());
            end
            if (axi2.w_valid) begin
                n_w2++;
                if (exp2_q.size() == 0) extra("t6_w_extra");
                else check("t6_w_data", axi2.w_data, exp2_q.pop_front());
                check("t6_w_last", u64'(axi2.w_last), 1);
                wd2 = axi2.w_data;
                b2_pend = 1;
            end
            if (axi2.ar_valid) begin
                n_ar2++;
                if (exp2_q.size() == 0) extra("t6_ar_extra");
                else check("t6_ar_addr", axi2.ar_addr, exp2_q.pop_front());
                r2_pend = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        for (int b = 0; b < NB; b++) begin
            exp_aw_q.push_back(64'h9000_0000 + u64'(b * 64));
            exp_ar_q.push_back(64'h9000_0000 + u64'(b * 64));
        end
        for (int k = 0; k < NB * BL; k++) begin
            exp_wd_q.push_back(64'hDEAD_BEEF + u64'(k));
            exp_wl_q.push_back((k % BL) == BL - 1);
        end
    endtask

    task automatic run_pass(input string nm, input bit st, input int br,
                            input int sb, input int dr, input int em,
                            input int ee, input bit ep);
        stall_en = st;
        bad_r = br;
        slverr_b = sb;
        decerr_r = dr;
        push_expected();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check({nm, "_busy"}, u64'(busy), 1);
        for (int i = 0; i < 3000 && !done; i++) tick();
        check({nm, "_done"}, u64'(done), 1);
        check({nm, "_busy_end"}, u64'(busy), 0);
        check({nm, "_pass"}, u64'(pass), u64'(ep));
        check({nm, "_mism"}, u64'(mism), u64'(em));
        check({nm, "_err"}, u64'(errc), u64'(ee));
        check({nm, "_q_left"},
              u64'(exp_aw_q.size() + exp_ar_q.size() + exp_wd_q.size()), 0);
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        start2 = 1'b0;
        stall_en = 0;
        bad_r = -1;
        slverr_b = -1;
        decerr_r = -1;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check("rst_busy", u64'(busy), 0);
        check("rst_done", u64'(done), 0);
        check("rst_pass", u64'(pass), 0);
        check("rst_mism", u64'(mism), 0);
        check("rst_err", u64'(errc), 0);
        check("rst_valids", u64'({axi.aw_valid, axi.w_valid, axi.ar_valid,
                                  axi.b_ready, axi.r_ready}), 0);

        run_pass("t1", 0, -1, -1, -1, 0, 0, 1);
        run_pass("t2", 0, 5, -1, -1, 1, 0, 0);
        run_pass("t3", 1, -1, -1, -1, 0, 0, 1);
        run_pass("t4", 0, -1, 2, 10, 0, 2, 0);

        stall_en = 0;
        bad_r = -1;
        slverr_b = -1;
        decerr_r = -1;
        push_expected();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 500 && !(axi.w_valid && wbeat == 3); i++) tick();
        check("t5_reached_beat3", u64'(axi.w_valid && wbeat == 3), 1);
        rst_i = 1'b1;
        exp_aw_q.delete();
        exp_ar_q.delete();
        exp_wd_q.delete();
        exp_wl_q.delete();
        tick();
        check("t5_valids", u64'({axi.aw_valid, axi.w_valid, axi.ar_valid,
                                 axi.b_ready, axi.r_ready}), 0);
        check("t5_busy", u64'(busy), 0);
        check("t5_done", u64'(done), 0);
        rst_i = 1'b0;
        tick();
        run_pass("t5", 0, -1, -1, -1, 0, 0, 1);

        exp2_q.push_back(64'h1000);
        exp2_q.push_back(64'h5);
        exp2_q.push_back(64'h1000);
        start2 = 1'b1;
        repeat (3) tick();
        start2 = 1'b0;
        for (int i = 0; i < 200 && !done2; i++) tick();
        check("t6_done", u64'(done2), 1);
        check("t6_pass", u64'(pass2), 1);
        check("t6_counts", u64'({mism2, errc2}), 0);
        check("t6_n_aw", u64'(n_aw2), 1);
        check("t6_n_w", u64'(n_w2), 1);
        check("t6_n_ar", u64'(n_ar2), 1);
        check("t6_n_r", u64'(n_r2), 1);
        check("t6_q_left", u64'(exp2_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
